// File: rtl/shift_arb_pkg.sv
// Shared constants and FSM state type for the shift_arbiter slice.
package shift_arb_pkg;

  localparam int SHIFT_W = 32;
  localparam int AMT_W   = 5;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} shift_arb_state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 32-bit logical barrel shifter built from log2 stages; zero fill both ways.
module barrel_shifter (
  input  logic [31:0] a,
  input  logic [4:0]  shift_amount,
  input  logic        left,
  output logic [31:0] res
);

  logic [31:0] w_stage;

  always_comb begin
    w_stage = a;
    for (int i = 0; i < 5; i++) begin
      if (shift_amount[i]) begin
        w_stage = left ? (w_stage << (1 << i)) : (w_stage >> (1 << i));
      end
    end
    res = w_stage;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter between NUM_REQ requesters.
// Optional per-requester saturating grant counters under SHIFT_ARB_STATS_EN.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*SHIFT_W-1:0] req_a,
  input  logic [NUM_REQ*AMT_W-1:0]   req_amt,
  input  logic [NUM_REQ-1:0]         req_left,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SHIFT_W-1:0]         rsp_res,
  output logic [ID_W-1:0]            rsp_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]   grant_count
`endif
);

  shift_arb_state_t   r_state;
  logic [SHIFT_W-1:0] r_a;
  logic [AMT_W-1:0]   r_amt;
  logic               r_left;
  logic [ID_W-1:0]    r_op_id;
  logic [ID_W-1:0]    r_last;
  logic               r_rsp_valid;
  logic [SHIFT_W-1:0] r_rsp_res;
  logic [ID_W-1:0]    r_rsp_id;

  logic               w_any;
  logic               w_arb_en;
  logic               w_accept;
  logic [ID_W-1:0]    w_pick;
  logic [SHIFT_W-1:0] w_shift_res;

  // Scan from the farthest candidate to the nearest so the one right after `last` wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign w_any    = |req_valid;
  assign w_arb_en = rst_n && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_accept = w_arb_en && w_any;
  assign w_pick   = rr_pick(req_valid, r_last);

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_pick] = 1'b1;
  end

  barrel_shifter u_shifter (
    .a            (r_a),
    .shift_amount (r_amt),
    .left         (r_left),
    .res          (w_shift_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_amt       <= '0;
      r_left      <= 1'b0;
      r_op_id     <= '0;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= req_a[w_pick*SHIFT_W +: SHIFT_W];
        r_amt   <= req_amt[w_pick*AMT_W +: AMT_W];
        r_left  <= req_left[w_pick];
        r_op_id <= w_pick;
        r_last  <= w_pick;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= SHIFT;
        end
        SHIFT: begin
          r_rsp_res   <= w_shift_res;
          r_rsp_id    <= r_op_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_accept ? SHIFT : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign rsp_id    = r_rsp_id;

`ifdef SHIFT_ARB_STATS_EN
  logic [CNT_W-1:0] r_grant_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
    end else if (w_accept && (r_grant_cnt[w_pick] != '1)) begin
      r_grant_cnt[w_pick] <= r_grant_cnt[w_pick] + 1'b1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_count[i*CNT_W +: CNT_W] = r_grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random self-checking bench for shift_arbiter with two requesters.
module tb_shift_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*5-1:0]  req_amt;
  logic [NUM_REQ-1:0]    req_left;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_res;
  logic [ID_W-1:0]       rsp_id;
`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_count;
`endif

  int checks   = 0;
  int failures = 0;

  shift_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_amt     (req_amt),
    .req_left    (req_left),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_res     (rsp_res),
    .rsp_id      (rsp_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one request and waits for its accept edge; wait_cyc = -1 on timeout.
  task automatic send(input int id, input logic [31:0] a, input logic [4:0] amt,
                      input logic lf, output int wait_cyc);
    req_a[id*32 +: 32] = a;
    req_amt[id*5 +: 5] = amt;
    req_left[id]       = lf;
    req_valid[id]      = 1'b1;
    wait_cyc           = -1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready[id]) begin
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        wait_cyc      = c;
        return;
      end
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
  endtask

  // Called right after the accept edge; lat counts edges from accept to rsp_valid, plus one.
  task automatic get_rsp(output logic [31:0] res, output logic [ID_W-1:0] id, output int lat);
    lat = -1;
    res = '0;
    id  = '0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin
        res = rsp_res;
        id  = rsp_id;
        lat = c + 1;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_amt   = '0;
    req_left  = '0;
    #3;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=00", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
    end
    checks++;
    if (rsp_res !== 32'h0) begin
      failures++;
      $display("FAIL reset_rsp_res got=%h exp=00000000", rsp_res);
    end
    checks++;
    if (rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_winner got=%b exp=01", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    int              wc, lat;
    logic [31:0]     res;
    logic [ID_W-1:0] rid;
    logic [31:0]     v_a   [3] = '{32'h0000_0001, 32'h8000_0000, 32'h1234_5678};
    logic [4:0]      v_amt [3] = '{5'd31, 5'd4, 5'd0};
    logic            v_lf  [3] = '{1'b1, 1'b0, 1'b1};
    int              v_id  [3] = '{0, 1, 0};
    logic [31:0]     v_exp [3] = '{32'h8000_0000, 32'h0800_0000, 32'h1234_5678};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(v_id[i], v_a[i], v_amt[i], v_lf[i], wc);
      get_rsp(res, rid, lat);
      checks++;
      if (res !== v_exp[i]) begin
        failures++;
        $display("FAIL single%0d_res got=%h exp=%h", i, res, v_exp[i]);
      end
      checks++;
      if (rid !== v_id[i][0]) begin
        failures++;
        $display("FAIL single%0d_id got=%0d exp=%0d", i, rid, v_id[i]);
      end
      checks++;
      if (wc < 0 || lat !== 2) begin
        failures++;
        $display("FAIL single%0d_latency got=%0d exp=2 (accept_wait=%0d)", i, lat, wc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          gq[$];
    int          ng, nr, last_acc, exp_id;
    bit          stop;
    logic [31:0] exp_res;
    do_reset();
    req_a     = {32'h0000_0010, 32'h0000_0001};
    req_amt   = {5'd4, 5'd1};
    req_left  = 2'b01;
    req_valid = 2'b11;
    ng        = 0;
    nr        = 0;
    last_acc  = -1;
    stop      = 1'b0;
    for (int c = 0; c < 60 && nr < 8; c++) begin
      #1;
      if (rsp_valid) begin
        exp_id  = (gq.size() > 0) ? gq.pop_front() : -1;
        exp_res = (exp_id == 0) ? 32'h0000_0002 : 32'h0000_0001;
        checks++;
        if (exp_id < 0 || rsp_id !== exp_id[0] || rsp_res !== exp_res) begin
          failures++;
          $display("FAIL b2b_rsp%0d got id=%0d res=%h exp id=%0d res=%h",
                   nr, rsp_id, rsp_res, exp_id, exp_res);
        end
        nr++;
      end
      if (!stop && (|(req_valid & req_ready))) begin
        checks++;
        if (req_ready !== ((ng % 2 == 0) ? 2'b01 : 2'b10)) begin
          failures++;
          $display("FAIL b2b_grant%0d got=%b exp=%b", ng, req_ready,
                   (ng % 2 == 0) ? 2'b01 : 2'b10);
        end
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc != 2) begin
            failures++;
            $display("FAIL b2b_gap%0d got=%0d exp=2", ng, c - last_acc);
          end
        end
        last_acc = c;
        gq.push_back(req_ready[1] ? 1 : 0);
        ng++;
        if (ng == 8) stop = 1'b1;
      end
      @(posedge clk);
      #1;
      if (stop) req_valid = '0;
    end
    req_valid = '0;
    checks++;
    if (ng != 8 || nr != 8) begin
      failures++;
      $display("FAIL b2b_counts got grants=%0d rsps=%0d exp 8/8", ng, nr);
    end
  endtask

  task automatic test_backpressure();
    int  wc;
    bit  seen;
    do_reset();
    rsp_ready = 1'b0;
    send(0, 32'h0000_00F0, 5'd4, 1'b0, wc);
    req_a[63:32]  = 32'h0000_0001;
    req_amt[9:5]  = 5'd3;
    req_left[1]   = 1'b1;
    req_valid     = 2'b10;
    seen          = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen || wc < 0) begin
      failures++;
      $display("FAIL bp_first_rsp got valid=%b exp=1", rsp_valid);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== 32'h0000_000F || rsp_id !== 1'b0 ||
          req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold%0d got valid=%b res=%h id=%0d ready=%b exp 1/0000000f/0/00",
                 c, rsp_valid, rsp_res, rsp_id, req_ready);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL bp_release_grant got=%b exp=10", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_shift_valid got=%b exp=0", rsp_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'h0000_0008 || rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL bp_second_rsp got valid=%b res=%h id=%0d exp 1/00000008/1",
               rsp_valid, rsp_res, rsp_id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int wc;
    do_reset();
    send(1, 32'hFFFF_0000, 5'd8, 1'b0, wc);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00 || wc < 0) begin
      failures++;
      $display("FAIL rstmid_ready got=%b exp=00 (accept_wait=%0d)", req_ready, wc);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_in_reset%0d got valid=%b exp=0", c, rsp_valid);
      end
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after%0d got valid=%b exp=0", c, rsp_valid);
      end
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_first_winner got=%b exp=01", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

`ifdef SHIFT_ARB_STATS_EN
  task automatic test_stats();
    int              wc, lat;
    logic [31:0]     res;
    logic [ID_W-1:0] rid;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(0, 32'h1, 5'd1, 1'b1, wc);
      get_rsp(res, rid, lat);
    end
    checks++;
    if (grant_count[15:0] !== 16'd3 || grant_count[31:16] !== 16'd0) begin
      failures++;
      $display("FAIL stats_count got=%h/%h exp=0003/0000", grant_count[15:0],
               grant_count[31:16]);
    end
    force dut.r_grant_cnt[0] = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.r_grant_cnt[0];
    send(0, 32'h1, 5'd1, 1'b1, wc);
    get_rsp(res, rid, lat);
    checks++;
    if (grant_count[15:0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_saturate got=%h exp=ffff", grant_count[15:0]);
    end
  endtask
`endif

  task automatic test_golden();
    int              wc, lat, id;
    logic [31:0]     a, res, exp_res;
    logic [4:0]      amt;
    logic            lf;
    logic [ID_W-1:0] rid;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      id      = int'($urandom_range(0, 1));
      a       = $urandom;
      amt     = 5'($urandom_range(0, 31));
      lf      = 1'($urandom_range(0, 1));
      exp_res = lf ? (a << amt) : (a >> amt);
      send(id, a, amt, lf, wc);
      get_rsp(res, rid, lat);
      checks++;
      if (wc < 0 || lat !== 2 || res !== exp_res || rid !== id[0]) begin
        failures++;
        $display("FAIL golden%0d a=%h amt=%0d left=%b got res=%h id=%0d lat=%0d exp res=%h id=%0d",
                 i, a, amt, lf, res, rid, lat, exp_res, id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SHIFT_ARB_STATS_EN
    test_stats();
`endif
    test_golden();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
